irq_onehot_arbiter: RTL and testbench



---
 rtl/irq_arb_pkg.sv | 14 +
 rtl/rr_pick8.sv | 38 +++
 rtl/irq_onehot_arbiter.sv | 119 +++++++++++
 tb/tb_irq_onehot_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_arb_pkg.sv
// Shared types for the interrupt one-hot arbiter: request width, grant index
// and the two-state grant FSM.
package irq_arb_pkg;

    localparam int NUM_REQ = 8;

    typedef logic [2:0] idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational picker: first eligible line scanning upward from ptr with
// wrap (rotating mode), or lowest eligible line (fixed mode).
module rr_pick8
    import irq_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] eligible,
    input  idx_t               ptr,
    input  logic               rr_en,
    output logic [NUM_REQ-1:0] onehot,
    output idx_t               idx,
    output logic               any
);

    idx_t start;
    idx_t cand;

    // NOTE: every output gets a default before the scan so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        start  = rr_en ? ptr : idx_t'(0);
        // 3-bit addition wraps 7 -> 0 naturally.
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = start + idx_t'(i);
            if (!any && eligible[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) begin
            onehot = NUM_REQ'(1) << idx;
        end
    end

endmodule

// File: rtl/irq_onehot_arbiter.sv
// Edge-captured interrupt requests with per-line mask, sticky pending and
// overflow, and a registered one-hot grant held until acknowledged.
module irq_onehot_arbiter
    import irq_arb_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [NUM_REQ-1:0] mask,
    input  logic               grant_ack,
    input  logic               ovf_clr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic               grant_valid,
    output logic [NUM_REQ-1:0] pending,
    output logic               overflow
);

    logic [NUM_REQ-1:0] req_q, req_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               valid_q, valid_d;
    logic               overflow_q, overflow_d;
    idx_t               rr_ptr_q, rr_ptr_d;
    idx_t               gidx_q, gidx_d;
    state_t             state_q, state_d;

    logic [NUM_REQ-1:0] evt;
    logic [NUM_REQ-1:0] clr;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_onehot;
    idx_t               pick_idx;
    logic               pick_any;

    rr_pick8 u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr_q),
        .rr_en    (ROUND_ROBIN != 0),
        .onehot   (pick_onehot),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    always_comb begin
        evt      = req_in & ~req_q;
        clr      = (state_q == GRANT && grant_ack) ? grant_q : '0;
        eligible = pending_q & ~mask;

        req_d     = req_in;
        // A fresh event on the bit being acked re-arms it rather than losing it.
        pending_d = (pending_q & ~clr) | evt;

        if ((evt & pending_q & ~clr) != '0) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        state_d  = state_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                    valid_d = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Mask is not consulted here: a live grant is never revoked.
                if (grant_ack) begin
                    grant_d  = '0;
                    valid_d  = 1'b0;
                    rr_ptr_d = gidx_q + idx_t'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q      <= '0;
            pending_q  <= '0;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            rr_ptr_q   <= '0;
            gidx_q     <= '0;
            state_q    <= IDLE;
        end else begin
            req_q      <= req_d;
            pending_q  <= pending_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            rr_ptr_q   <= rr_ptr_d;
            gidx_q     <= gidx_d;
            state_q    <= state_d;
        end
    end

    assign grant_onehot = grant_q;
    assign grant_valid  = valid_q;
    assign pending      = pending_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_irq_onehot_arbiter.sv
// Bench for irq_onehot_arbiter: a rotating-priority and a fixed-priority
// instance share stimulus and are compared every cycle against a reference model.
module tb_irq_onehot_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic       grant_ack;
    logic       ovf_clr;

    // Index 0: ROUND_ROBIN=1, index 1: ROUND_ROBIN=0.
    logic [1:0][7:0] gnt;
    logic [1:0][7:0] pnd;
    logic [1:0]      vld;
    logic [1:0]      ovf;

    irq_onehot_arbiter #(.ROUND_ROBIN(1)) dut_rr (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_in       (req_in),
        .mask         (mask),
        .grant_ack    (grant_ack),
        .ovf_clr      (ovf_clr),
        .grant_onehot (gnt[0]),
        .grant_valid  (vld[0]),
        .pending      (pnd[0]),
        .overflow     (ovf[0])
    );

    irq_onehot_arbiter #(.ROUND_ROBIN(0)) dut_fp (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_in       (req_in),
        .mask         (mask),
        .grant_ack    (grant_ack),
        .ovf_clr      (ovf_clr),
        .grant_onehot (gnt[1]),
        .grant_valid  (vld[1]),
        .pending      (pnd[1]),
        .overflow     (ovf[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit run_cmp  = 1'b1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the granted line is an index (-1 = none); pending and
    // the last-sampled request level are plain bit vectors.
    logic [7:0] m_reqq [2];
    logic [7:0] m_pend [2];
    logic       m_ovf  [2];
    int         m_gidx [2];
    int         m_ptr  [2];
    logic [7:0] m_evt, m_clr, m_old;

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_reqq[d] = '0; m_pend[d] = '0; m_ovf[d] = 1'b0;
            m_gidx[d] = -1; m_ptr[d] = 0;
        end
    end

    function automatic int pick(input logic [7:0] elig, input int ptr, input bit rr);
        int k;
        for (int off = 0; off < 8; off++) begin
            k = ((rr ? ptr : 0) + off) % 8;
            if (elig[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_gnt(input int gi);
        return (gi >= 0) ? (8'd1 << gi) : 8'd0;
    endfunction

    function automatic logic [7:0] enc(input logic [7:0] oh);
        for (int i = 0; i < 8; i++) if (oh[i]) return 8'(i);
        return 8'd0;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_reqq[d] = '0; m_pend[d] = '0; m_ovf[d] = 1'b0;
                m_gidx[d] = -1; m_ptr[d] = 0;
            end else begin
                m_evt = req_in & ~m_reqq[d];
                m_clr = (m_gidx[d] >= 0 && grant_ack) ? exp_gnt(m_gidx[d]) : 8'd0;
                m_old = m_pend[d];
                if ((m_evt & m_old & ~m_clr) != 0) m_ovf[d] = 1'b1;
                else if (ovf_clr)                  m_ovf[d] = 1'b0;
                m_pend[d] = (m_old & ~m_clr) | m_evt;
                if (m_gidx[d] >= 0) begin
                    if (grant_ack) begin
                        m_ptr[d]  = (m_gidx[d] + 1) % 8;
                        m_gidx[d] = -1;
                    end
                end else begin
                    m_gidx[d] = pick(m_old & ~mask, m_ptr[d], d == 0);
                end
                m_reqq[d] = req_in;
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            for (int d = 0; d < 2; d++) begin
                string t;
                t = (d == 0) ? "rr" : "fp";
                check({t, ".grant"},    gnt[d], exp_gnt(m_gidx[d]));
                check({t, ".valid"},    8'(vld[d]), 8'(m_gidx[d] >= 0));
                check({t, ".pending"},  pnd[d], m_pend[d]);
                check({t, ".overflow"}, 8'(ovf[d]), 8'(m_ovf[d]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_in = 8'h00; mask = 8'h00; grant_ack = 1'b1;
        while (!(pnd == '0 && vld == '0) && n < 40) begin
            step();
            n++;
        end
        check("drain.pend_rr", pnd[0], 8'h00);
        check("drain.pend_fp", pnd[1], 8'h00);
        check("drain.valid",   8'(vld), 8'h00);
        grant_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_in = 8'hFF; mask = 8'h00; grant_ack = 1'b0; ovf_clr = 1'b0;

        // Reset with all requests high.
        repeat (3) step();
        check("rst.grant",   gnt[0], 8'h00);
        check("rst.valid",   8'(vld), 8'h00);
        check("rst.pending", pnd[0], 8'h00);
        check("rst.ovf",     8'(ovf), 8'h00);
        rst_n = 1'b1;
        step();
        check("rel.pend_rr", pnd[0], 8'hFF);
        check("rel.pend_fp", pnd[1], 8'hFF);
        check("rel.valid",   8'(vld), 8'h00);
        step();
        check("rel.gnt_rr", gnt[0], 8'h01);
        check("rel.gnt_fp", gnt[1], 8'h01);
        check("rel.valid1", 8'(vld), 8'h03);
        check("rel.enc",    enc(gnt[0]), 8'h00);
        drain();

        // Single event on line 4, grant held without ack.
        req_in = 8'h10;
        step();
        check("s2.pend", pnd[0], 8'h10);
        req_in = 8'h00;
        step();
        check("s2.gnt", gnt[0], 8'h10);
        repeat (5) begin
            step();
            check("s2.hold", gnt[0], 8'h10);
            check("s2.hold_fp", gnt[1], 8'h10);
        end
        grant_ack = 1'b1;
        step();
        grant_ack = 1'b0;
        check("s2.ack_pend",  pnd[0], 8'h00);
        check("s2.ack_valid", 8'(vld[0]), 8'h00);

        // Rotating pointer at 5 versus fixed priority on lines 0 and 5.
        req_in = 8'h21;
        step();
        req_in = 8'h00;
        step();
        check("s3.gnt_rr", gnt[0], 8'h20);
        check("s3.gnt_fp", gnt[1], 8'h01);
        grant_ack = 1'b1;
        step();
        grant_ack = 1'b0;
        step();
        check("s3.gnt2_rr", gnt[0], 8'h01);
        check("s3.gnt2_fp", gnt[1], 8'h20);
        grant_ack = 1'b1;
        step();
        grant_ack = 1'b0;
        check("s3.pend", pnd[0], 8'h00);

        // Masked line 2 skipped; mask change during grant does not revoke.
        mask = 8'h04; req_in = 8'h0C;
        step();
        req_in = 8'h00;
        check("s4.pend", pnd[0], 8'h0C);
        step();
        check("s4.gnt_rr", gnt[0], 8'h08);
        check("s4.gnt_fp", gnt[1], 8'h08);
        mask = 8'h08;
        step();
        check("s4.keep", gnt[0], 8'h08);
        grant_ack = 1'b1; mask = 8'h00;
        step();
        grant_ack = 1'b0;
        check("s4.pend2", pnd[0], 8'h04);
        step();
        check("s4.gnt2", gnt[0], 8'h04);

        // New event on line 2 in the same cycle it is acked.
        grant_ack = 1'b1; req_in = 8'h04;
        step();
        grant_ack = 1'b0; req_in = 8'h00;
        check("s5.pend",  pnd[0], 8'h04);
        check("s5.ovf",   8'(ovf), 8'h00);
        check("s5.idle",  8'(vld), 8'h00);
        step();
        check("s5.regnt", gnt[0], 8'h04);
        grant_ack = 1'b1;
        step();
        grant_ack = 1'b0;

        // Overflow set, cleared, and set-wins-over-clear.
        req_in = 8'h40;
        step();
        req_in = 8'h00;
        step();
        check("s6.gnt", gnt[0], 8'h40);
        req_in = 8'h40;
        step();
        req_in = 8'h00;
        check("s6.ovf_set", 8'(ovf), 8'h03);
        ovf_clr = 1'b1;
        step();
        check("s6.ovf_clr", 8'(ovf), 8'h00);
        req_in = 8'h40;
        step();
        ovf_clr = 1'b0; req_in = 8'h00;
        check("s6.ovf_win", 8'(ovf), 8'h03);
        drain();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;

        // Randomized traffic with occasional resets.
        repeat (3000) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            req_in    = req_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 7) == 0) mask = 8'($urandom) & 8'($urandom);
            grant_ack = ($urandom_range(0, 2) == 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            step();
        end

        run_cmp = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
